// File: rtl/kws_posterior_smoother.sv
// Keyword posterior smoother: per-class moving average, best non-background class, threshold + hold-off.
// Latency: det_valid NUM_CLASSES+1 cycles after frame acceptance; one frame per NUM_CLASSES+2 cycles.
// Backpressure: score_ready only in IDLE; optional margin gate via KWS_SMOOTH_MARGIN_EN.
module kws_posterior_smoother #(
    parameter int NUM_CLASSES  = 10,
    parameter int SCORE_BITS   = 8,
    parameter int WINDOW       = 8,
    parameter int HOLDOFF_BITS = 8,
    parameter int BG_CLASS     = 0,
    localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CLASSES*SCORE_BITS-1:0] score_in,
    input  logic                              score_valid,
    output logic                              score_ready,
    input  logic [SCORE_BITS-1:0]             threshold,
    input  logic [HOLDOFF_BITS-1:0]           holdoff_frames,
    input  logic                              clear,
`ifdef KWS_SMOOTH_MARGIN_EN
    input  logic [SCORE_BITS-1:0]             margin,
`endif
    output logic                              det_valid,
    output logic [CLS_W-1:0]                  det_class,
    output logic [SCORE_BITS-1:0]             det_score,
    output logic                              busy
);

    localparam int LOG_W  = $clog2(WINDOW);
    localparam int SUM_W  = SCORE_BITS + LOG_W;
    localparam int FILL_W = LOG_W + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WINDOW);
    localparam logic [CLS_W-1:0]  LAST_CLS  = CLS_W'(NUM_CLASSES - 1);
    localparam logic [CLS_W-1:0]  BG_IDX    = CLS_W'(BG_CLASS);

    typedef enum logic [1:0] {IDLE, UPDATE, DECIDE} state_t;

    state_t                   state;
    logic [SCORE_BITS-1:0]    frame_q [NUM_CLASSES];
    logic [SCORE_BITS-1:0]    hist [WINDOW][NUM_CLASSES];
    logic [SUM_W-1:0]         sums [NUM_CLASSES];
    logic [CLS_W-1:0]         cls_idx;
    logic [LOG_W-1:0]         wr_ptr;
    logic [FILL_W-1:0]        fill_cnt;
    logic [HOLDOFF_BITS-1:0]  holdoff_cnt;
    logic                     best_vld;
    logic [CLS_W-1:0]         best_cls;
    logic [SCORE_BITS-1:0]    best_avg;
`ifdef KWS_SMOOTH_MARGIN_EN
    logic [SCORE_BITS-1:0]    second_avg;
`endif

    logic [SCORE_BITS-1:0]    new_score;
    logic [SCORE_BITS-1:0]    old_score;
    logic [SUM_W-1:0]         new_sum;
    logic [SCORE_BITS-1:0]    new_avg;
    logic [FILL_W-1:0]        fill_nxt;
    logic                     detect;

    assign score_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    // Until the window is full the evicted sample is treated as zero, so history needs no init.
    always_comb begin
        new_score = frame_q[cls_idx];
        old_score = (fill_cnt == FILL_FULL) ? hist[wr_ptr][cls_idx] : '0;
        new_sum   = sums[cls_idx] + SUM_W'(new_score) - SUM_W'(old_score);
        new_avg   = new_sum[SUM_W-1:LOG_W];
        fill_nxt  = (fill_cnt == FILL_FULL) ? fill_cnt : fill_cnt + FILL_W'(1);
        detect    = (fill_nxt == FILL_FULL) && best_vld && (best_avg >= threshold)
                    && (holdoff_cnt == '0);
`ifdef KWS_SMOOTH_MARGIN_EN
        detect    = detect && ((best_avg - second_avg) >= margin);
`endif
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && score_valid && !clear) begin
            for (int c = 0; c < NUM_CLASSES; c++)
                frame_q[c] <= score_in[c*SCORE_BITS +: SCORE_BITS];
        end
        if (state == UPDATE && !clear)
            hist[wr_ptr][cls_idx] <= new_score;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            for (int c = 0; c < NUM_CLASSES; c++) sums[c] <= '0;
            cls_idx     <= '0;
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            holdoff_cnt <= '0;
            best_vld    <= 1'b0;
            best_cls    <= '0;
            best_avg    <= '0;
`ifdef KWS_SMOOTH_MARGIN_EN
            second_avg  <= '0;
`endif
            det_valid   <= 1'b0;
            det_class   <= '0;
            det_score   <= '0;
        end else if (clear) begin
            state       <= IDLE;
            for (int c = 0; c < NUM_CLASSES; c++) sums[c] <= '0;
            cls_idx     <= '0;
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            holdoff_cnt <= '0;
            best_vld    <= 1'b0;
            det_valid   <= 1'b0;
        end else begin
            det_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (score_valid) begin
                        cls_idx    <= '0;
                        best_vld   <= 1'b0;
                        best_cls   <= '0;
                        best_avg   <= '0;
`ifdef KWS_SMOOTH_MARGIN_EN
                        second_avg <= '0;
`endif
                        state      <= UPDATE;
                    end
                end
                UPDATE: begin
                    sums[cls_idx] <= new_sum;
                    // Strict greater-than keeps the lowest index on ties.
                    if (cls_idx != BG_IDX) begin
                        if (!best_vld || new_avg > best_avg) begin
                            best_vld   <= 1'b1;
                            best_cls   <= cls_idx;
                            best_avg   <= new_avg;
`ifdef KWS_SMOOTH_MARGIN_EN
                            if (best_vld) second_avg <= best_avg;
                        end else if (new_avg > second_avg) begin
                            second_avg <= new_avg;
`endif
                        end
                    end
                    if (cls_idx == LAST_CLS) state <= DECIDE;
                    else                     cls_idx <= cls_idx + CLS_W'(1);
                end
                DECIDE: begin
                    wr_ptr   <= wr_ptr + LOG_W'(1);
                    fill_cnt <= fill_nxt;
                    if (detect) begin
                        det_valid   <= 1'b1;
                        det_class   <= best_cls;
                        det_score   <= best_avg;
                        holdoff_cnt <= holdoff_frames;
                    end else if (holdoff_cnt != '0) begin
                        holdoff_cnt <= holdoff_cnt - HOLDOFF_BITS'(1);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/kws_posterior_smoother.md
Name: kws_posterior_smoother

Overview:
Post-classifier decision stage for the keyword-spotting pipeline. It consumes one per-frame class-score vector (e.g. softmax output), keeps a sliding window of the last WINDOW frames per class, and computes each class's moving average. It selects the best non-background class and applies a threshold and a refractory hold-off. It emits a single-cycle detection event, replacing the raw per-frame registered result with a stable keyword decision.

Parameters:
NUM_CLASSES, 10, number of classes in score vector
SCORE_BITS, 8, unsigned width of each class score
WINDOW, 8, smoothing depth in frames; power of two, >=2
HOLDOFF_BITS, 8, width of hold-off frame counter
BG_CLASS, 0, index of filler/background class; never reported

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
score_in  input  NUM_CLASSES*SCORE_BITS  class c at bits [c*SCORE_BITS +: SCORE_BITS]
score_valid  input  1  score_in valid
score_ready  output  1  block can accept a frame
threshold  input  SCORE_BITS  minimum smoothed score for detection
holdoff_frames  input  HOLDOFF_BITS  frames suppressed after a detection
clear  input  1  synchronous flush of history and hold-off
det_valid  output  1  one-cycle detection pulse
det_class  output  $clog2(NUM_CLASSES)  detected class index
det_score  output  SCORE_BITS  smoothed score of detected class
busy  output  1  frame being processed (state != IDLE)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, score_ready=1, det_valid=0, det_class=0, det_score=0, busy=0; sums, fill_cnt, wr_ptr, holdoff_cnt=0. History RAM is not reset.
- Handshake: frame accepted when score_valid && score_ready. score_ready=1 only in IDLE. score_in is captured into an internal register on acceptance. A held score_valid while not ready is not consumed twice.
- FSM IDLE -> UPDATE -> DECIDE -> IDLE.
- UPDATE: NUM_CLASSES cycles, class c in cycle c.
  - old = (fill_cnt==WINDOW) ? hist[wr_ptr][c] : 0. Warm-up forces 0, so no RAM init is needed.
  - sum[c] <= sum[c] + new - old, with sum width SCORE_BITS+log2(WINDOW) and no overflow possible.
  - hist[wr_ptr][c] <= new.
  - avg = new_sum >> log2(WINDOW), computed from the updated sum.
  - Argmax over c != BG_CLASS uses strict greater-than, so ties resolve to the lowest index.
- DECIDE (1 cycle):
  - wr_ptr advances, wrapping WINDOW-1 -> 0. fill_cnt increments, saturating at WINDOW.
  - Detection condition: fill_cnt (post-increment) == WINDOW && max_avg >= threshold && holdoff_cnt == 0.
  - On detection: det_valid=1 for exactly this cycle; det_class, det_score updated; holdoff_cnt <= holdoff_frames.
  - Otherwise: holdoff_cnt decrements if nonzero; det_class and det_score hold their previous values.
- Latency: acceptance at edge 0; det_valid high in cycle NUM_CLASSES+1. Throughput: one frame per NUM_CLASSES+2 cycles.
- NUM_CLASSES==1 with BG_CLASS==0: no detection is ever possible.
- clear=1 at any state:
  - next cycle state=IDLE; sums, fill_cnt, wr_ptr, holdoff_cnt=0; det_valid=0.
  - Any in-flight frame is discarded. clear has priority over acceptance in the same cycle.
  - det_class and det_score hold their values.
- Reset mid-UPDATE: same as reset; the partial frame is lost and warm-up restarts.

Optional Feature:
KWS_SMOOTH_MARGIN_EN:
- When defined: adds input port margin [SCORE_BITS]. UPDATE also tracks second-best avg among non-background classes. Detection additionally requires max_avg - second_avg >= margin (unsigned, max>=second guaranteed). Ties give a difference of 0.
- When undefined: no margin port, no second-best logic; the decision is threshold-only.

Test Plan:
- Warm-up: WINDOW=8, threshold=128, holdoff=0, frames with class3=200 and others 0 -> no det on frames 1-7; frame 8 det_valid one cycle at NUM_CLASSES+1=11 cycles after acceptance, det_class=3, det_score=200.
- Hold-off: same stimulus continuous, holdoff_frames=3 -> detections on frames 8, 12, 16, 20 only.
- Background/tie: class0=255 every frame -> no det. Then class2=class5=150 for 8 frames after clear -> det_class=2, det_score=150.
- Threshold/averaging: class4 alternates 100/200, threshold=160 -> avg=150, no det. threshold=150 -> det on frame 8 with det_score=150.
- Backpressure: score_valid held high continuously -> score_ready low for 11 of every 12 cycles; exactly one frame accepted per 12 cycles; busy matches.
- Clear/reset mid-operation: assert clear during UPDATE of frame 10, then resume class3=200 frames -> no det until 8 new frames. rst_n low mid-UPDATE -> all outputs 0, score_ready=1 next cycle.
